// File: rtl/rsa32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rsa32_pkg
//  Purpose  : Shared register offsets, bit indices and FSM encoding for the
//             rsa32 APB control front-end.
//  Revision : 1.0  initial release
// ============================================================================
package rsa32_pkg;

    // Word offsets, i.e. the value of paddr[4:2]
    localparam logic [2:0] ADDR_BASE   = 3'd0;
    localparam logic [2:0] ADDR_EXP    = 3'd1;
    localparam logic [2:0] ADDR_N      = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_RESULT = 3'd5;
    localparam logic [2:0] ADDR_CYCLES = 3'd6;

    // CTRL register bits
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // STATUS register bits
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    // FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : rsa32_pkg
`default_nettype wire

// File: rtl/rsa32_end_edge.sv
`default_nettype none
// ============================================================================
//  Module   : rsa32_end_edge
//  Purpose  : Two-flop sampler of the core completion flag with a rising-edge
//             pulse output. A flag that stays high produces no further pulses.
//  Revision : 1.0  initial release
// ============================================================================
module rsa32_end_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_end,
    output logic o_rise
);

    logic r_end_s1;
    logic r_end_s2;

    // Sample the completion flag and keep one cycle of history for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_end_s1 <= 1'b0;
            r_end_s2 <= 1'b0;
        end else begin
            r_end_s1 <= i_end;
            r_end_s2 <= r_end_s1;
        end
    end

    assign o_rise = r_end_s1 & ~r_end_s2;

endmodule : rsa32_end_edge
`default_nettype wire

// File: rtl/rsa32_apb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rsa32_apb_ctrl
//  Purpose  : APB3 slave front-end for the rsa32 modular-exponentiation core:
//             operand registers, start pulse, result capture, status, irq
//             and a saturating compute-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
module rsa32_apb_ctrl
    import rsa32_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic [31:0]       i_pwdata,
    output logic [31:0]       o_prdata,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic              o_start,
    output logic [31:0]       o_base,
    output logic [31:0]       o_exp,
    output logic [31:0]       o_N,
    input  logic [31:0]       i_result,
    input  logic              i_end,
    output logic              o_irq
);

    logic [0:0]       r_state;
    logic             r_start;
    logic             r_irq_en;
    logic             r_done;
    logic             r_err;
    logic [31:0]      r_base;
    logic [31:0]      r_exp;
    logic [31:0]      r_n;
    logic [31:0]      r_result;
    logic [CNT_W-1:0] r_cycles;

    logic             w_access;
    logic             w_wr;
    logic [2:0]       w_idx;
    logic             w_busy;
    logic             w_wr_operand;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_start_req;
    logic             w_start_fire;
    logic             w_start_err;
    logic             w_end_rise;
    logic             w_complete;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // Only paddr[4:2] selects a register; the remaining address bits alias
    assign w_unused = ^{i_paddr[ADDR_W-1:5], i_paddr[1:0]};

    assign w_access     = i_psel & i_penable;
    assign w_wr         = w_access & i_pwrite;
    assign w_idx        = i_paddr[4:2];
    assign w_busy       = (r_state == ST_RUN);
    assign w_wr_operand = w_wr & ((w_idx == ADDR_BASE) | (w_idx == ADDR_EXP) | (w_idx == ADDR_N));
    assign w_wr_ctrl    = w_wr & (w_idx == ADDR_CTRL);
    assign w_wr_status  = w_wr & (w_idx == ADDR_STATUS);
    assign w_start_req  = w_wr_ctrl & i_pwdata[CTRL_START_BIT];
    assign w_start_fire = w_start_req & ~w_busy;
    assign w_start_err  = w_start_req & w_busy;

    // The o_start cycle is excluded so a flag rising just before the start is stale
    assign w_complete   = w_busy & w_end_rise & ~r_start;

    rsa32_end_edge u_end_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_end  (i_end),
        .o_rise (w_end_rise)
    );

    // Operand registers are frozen while the core is running
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base <= '0;
            r_exp  <= '0;
            r_n    <= '0;
        end else if (w_wr_operand && !w_busy) begin
            case (w_idx)
                ADDR_BASE: r_base <= i_pwdata;
                ADDR_EXP:  r_exp  <= i_pwdata;
                default:   r_n    <= i_pwdata;
            endcase
        end
    end

    // FSM, start pulse and status flags; completion set beats a same-cycle W1C
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_start  <= 1'b0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_start <= w_start_fire;
            if (w_wr_ctrl) begin
                r_irq_en <= i_pwdata[CTRL_IRQ_EN_BIT];
            end
            if (w_start_fire) begin
                r_state <= ST_RUN;
            end else if (w_complete) begin
                r_state <= ST_IDLE;
            end
            if (w_complete) begin
                r_result <= i_result;
            end
            if (w_complete) begin
                r_done <= 1'b1;
            end else if (w_start_fire || (w_wr_status && i_pwdata[STAT_DONE_BIT])) begin
                r_done <= 1'b0;
            end
            if (w_start_err) begin
                r_err <= 1'b1;
            end else if (w_wr_status && i_pwdata[STAT_ERR_BIT]) begin
                r_err <= 1'b0;
            end
        end
    end

    // Compute-cycle counter: cleared on start, counts every RUN cycle, saturates
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycles <= '0;
        end else if (w_start_fire) begin
            r_cycles <= '0;
        end else if (w_busy && (r_cycles != {CNT_W{1'b1}})) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    // Read mux; reserved and write-only fields read as zero
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            ADDR_BASE:   w_rdata = r_base;
            ADDR_EXP:    w_rdata = r_exp;
            ADDR_N:      w_rdata = r_n;
            ADDR_CTRL:   w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
            ADDR_STATUS: begin
                w_rdata[STAT_BUSY_BIT] = w_busy;
                w_rdata[STAT_DONE_BIT] = r_done;
                w_rdata[STAT_ERR_BIT]  = r_err;
            end
            ADDR_RESULT: w_rdata = r_result;
            ADDR_CYCLES: w_rdata = 32'(r_cycles);
            default:     w_rdata = '0;
        endcase
    end

    assign o_prdata  = w_access ? w_rdata : 32'd0;
    assign o_pready  = 1'b1;
    assign o_pslverr = w_busy & (w_wr_operand | w_start_req);
    assign o_start   = r_start;
    assign o_base    = r_base;
    assign o_exp     = r_exp;
    assign o_N       = r_n;
    assign o_irq     = r_done & r_irq_en;

endmodule : rsa32_apb_ctrl
`default_nettype wire

// File: tb/tb_rsa32_apb_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rsa32_apb_ctrl
//  Purpose  : Self-checking bench for rsa32_apb_ctrl with a register-level
//             reference model and a behavioural modexp core stand-in.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rsa32_apb_ctrl;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 32;

    localparam logic [2:0] A_BASE = 3'd0, A_EXP = 3'd1, A_N = 3'd2, A_CTRL = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4, A_RES = 3'd5, A_CYC = 3'd6, A_RSV = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, start_o, irq;
    logic [31:0] base_o, exp_o, n_o;
    logic [31:0] core_result = '0;
    logic        core_end = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int tb_cyc = 0;
    int start_pulses = 0;

    // Reference model state
    logic [31:0] m_base, m_exp, m_n, m_result, m_cycles;
    logic        m_irq_en, m_busy, m_done, m_err;
    int          m_starts = 0;

    rsa32_apb_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_paddr   (paddr),
        .i_pwdata  (pwdata),
        .o_prdata  (prdata),
        .o_pready  (pready),
        .o_pslverr (pslverr),
        .o_start   (start_o),
        .o_base    (base_o),
        .o_exp     (exp_o),
        .o_N       (n_o),
        .i_result  (core_result),
        .i_end     (core_end),
        .o_irq     (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Start pulses sampled mid-cycle: a pulse longer than one cycle counts twice
    always @(negedge clk) if (start_o === 1'b1) start_pulses <= start_pulses + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
        longint unsigned r, x;
        r = 64'd1 % 64'(n);
        x = 64'(b) % 64'(n);
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % 64'(n);
            x = (x * x) % 64'(n);
        end
        return r[31:0];
    endfunction

    function automatic logic [7:0] mk_addr(input logic [2:0] idx);
        logic [7:0] a;
        a = 8'($urandom);
        a[4:2] = idx;
        return a;
    endfunction

    task automatic model_reset();
        m_base = '0; m_exp = '0; m_n = '0; m_result = '0; m_cycles = '0;
        m_irq_en = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        err = 1'b0;
        case (a[4:2])
            A_BASE: if (m_busy) err = 1'b1; else m_base = d;
            A_EXP:  if (m_busy) err = 1'b1; else m_exp  = d;
            A_N:    if (m_busy) err = 1'b1; else m_n    = d;
            A_CTRL: begin
                m_irq_en = d[1];
                if (d[0]) begin
                    if (m_busy) begin
                        err = 1'b1;
                        m_err = 1'b1;
                    end else begin
                        m_busy = 1'b1; m_done = 1'b0; m_cycles = '0;
                        m_starts++;
                    end
                end
            end
            A_STAT: begin
                if (d[1]) m_done = 1'b0;
                if (d[2]) m_err = 1'b0;
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a[4:2])
            A_BASE:  return m_base;
            A_EXP:   return m_exp;
            A_N:     return m_n;
            A_CTRL:  return {30'd0, m_irq_en, 1'b0};
            A_STAT:  return {29'd0, m_err, m_done, m_busy};
            A_RES:   return m_result;
            A_CYC:   return m_cycles;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_complete(input logic [31:0] r, input int cyc);
        m_result = r; m_done = 1'b1; m_busy = 1'b0; m_cycles = 32'(cyc);
    endtask

    // Bus tasks are entered 1ns after a rising edge and return 1ns after one
    task automatic bus_wr(input string tag, input logic [2:0] idx, input logic [31:0] d);
        logic [7:0] a;
        logic       exp_err, got_err;
        a = mk_addr(idx);
        model_write(a, d, exp_err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        got_err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk({tag, "_slverr"}, 32'(got_err), 32'(exp_err));
    endtask

    task automatic bus_rd(input string tag, input logic [2:0] idx);
        logic [7:0]  a;
        logic [31:0] got;
        a = mk_addr(idx);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        got = prdata;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk(tag, got, model_read(a));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One operation: program operands, start, optional busy traffic, complete.
    // race=1 lands a DONE W1C on the completion edge; keep_end leaves i_end high.
    task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n,
                          input logic irq_en, input int nbusy, input bit race, input bit keep_end);
        int          start_cyc, k, sel;
        logic [31:0] res;
        bus_wr("wr_base", A_BASE, b);
        bus_wr("wr_exp", A_EXP, e);
        bus_wr("wr_n", A_N, n);
        bus_wr("wr_start", A_CTRL, {30'd0, irq_en, 1'b1});
        start_cyc = tb_cyc;
        chk("start_high", 32'(start_o), 32'd1);
        for (int i = 0; i < nbusy; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: idle(1);
                1: bus_wr("busy_wr_operand", 3'($urandom_range(0, 2)), $urandom);
                2: bus_wr("busy_wr_start", A_CTRL, {30'd0, irq_en, 1'b1});
                default: bus_rd("busy_status", A_STAT);
            endcase
        end
        bus_rd("run_status", A_STAT);
        chk("base_stable", base_o, m_base);
        chk("n_stable", n_o, m_n);
        if (core_end) begin
            core_end = 1'b0;
            idle(1);
        end
        k = tb_cyc - start_cyc;
        res = modexp(b, e, n);
        core_result = res;
        core_end = 1'b1;
        if (race) begin
            bus_wr("race_w1c", A_STAT, 32'h2);
        end else begin
            idle(2);
        end
        model_complete(res, k + 2);
        bus_rd("done_status", A_STAT);
        bus_rd("result", A_RES);
        bus_rd("cycles", A_CYC);
        chk("exp_stable", exp_o, m_exp);
        chk("irq_level", 32'(irq), 32'(m_done & m_irq_en));
        chk("start_count", 32'(start_pulses), 32'(m_starts));
        if (!keep_end) core_end = 1'b0;
    endtask

    initial begin : watchdog
        #5_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : main
        logic [31:0] rb, re, rn;
        model_reset();

        // Reset asserted mid-cycle
        #13 rst = 1'b1;
        #20 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_pready", 32'(pready), 32'd1);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_base", base_o, 32'd0);
        chk("rst_exp", exp_o, 32'd0);
        chk("rst_n", n_o, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 8; i++) bus_rd("rst_reg", 3'(i));

        // Basic operation: 2^10 mod 1000 = 24
        run_op(32'd2, 32'd10, 32'd1000, 1'b1, 0, 1'b0, 1'b0);
        chk("basic_result", m_result, 32'd24);

        // Busy protection: explicit operand and start writes during RUN
        bus_wr("wr_base", A_BASE, 32'd3);
        bus_wr("wr_start", A_CTRL, 32'h3);
        bus_wr("busy_base5", A_BASE, 32'd5);
        bus_wr("busy_start", A_CTRL, 32'h3);
        chk("busy_base_kept", base_o, 32'd3);
        core_result = 32'hDEAD_BEEF;
        core_end = 1'b1;
        idle(3);
        model_complete(32'hDEAD_BEEF, 0);
        bus_rd("busy_err_status", A_STAT);
        bus_rd("busy_result", A_RES);
        chk("busy_starts", 32'(start_pulses), 32'(m_starts));
        core_end = 1'b0;

        // W1C of DONE on the completion edge; ERR set by a busy start beforehand
        bus_wr("wr_start", A_CTRL, 32'h3);
        bus_wr("race_busy_start", A_CTRL, 32'h3);
        idle(2);
        core_result = 32'd77;
        core_end = 1'b1;
        bus_wr("race_w1c", A_STAT, 32'h2);
        model_complete(32'd77, 0);
        chk("race_irq", 32'(irq), 32'd1);
        bus_rd("race_status", A_STAT);
        bus_wr("clr_done_err", A_STAT, 32'h6);
        chk("irq_dropped", 32'(irq), 32'd0);
        bus_rd("clr_status", A_STAT);
        core_end = 1'b0;

        // Race again through the full operation path, then a stale-end restart
        run_op(32'd7, 32'd13, 32'd101, 1'b1, 2, 1'b1, 1'b1);
        run_op(32'd3, 32'd200, 32'd65537, 1'b1, 3, 1'b0, 1'b0);

        // Reset pulse during RUN abandons the operation
        bus_wr("wr_start", A_CTRL, 32'h3);
        idle(3);
        #3 rst = 1'b1;
        #4 rst = 1'b0;
        model_reset();
        idle(1);
        bus_rd("rstrun_status", A_STAT);
        bus_rd("rstrun_result", A_RES);
        bus_rd("rstrun_base", A_BASE);
        chk("rstrun_irq", 32'(irq), 32'd0);
        run_op(32'd5, 32'd3, 32'd13, 1'b0, 1, 1'b0, 1'b0);

        // Randomised operations with idle-time register traffic
        for (int t = 0; t < 10; t++) begin
            rb = $urandom;
            re = $urandom;
            rn = $urandom;
            if (rn == 32'd0) rn = 32'd1;
            run_op(rb, re, rn, 1'($urandom), $urandom_range(0, 5), 1'b0, 1'($urandom));
            bus_wr("ro_write", 3'($urandom_range(5, 7)), $urandom);
            bus_wr("stat_write", A_STAT, $urandom);
            bus_rd("rand_read", 3'($urandom_range(0, 7)));
            bus_rd("rand_status", A_STAT);
            chk("rand_irq", 32'(irq), 32'(m_done & m_irq_en));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rsa32_apb_ctrl
`default_nettype wire
